// File: rtl/spi_target_controller_if.sv
// Pin-side and FIFO-side signals of the SPI target controller.
// The controller uses the slave modport; the driving environment uses master.
interface spi_target_controller_if;
  logic        sclk_i;
  logic        cs_n_i;
  logic        mosi_i;
  logic        miso_o;
  logic        miso_oe_o;
  logic        cpol_i;
  logic        cpha_i;
  logic [3:0]  data_size_i;
  logic [15:0] tx_data_i;
  logic        tx_empty_i;
  logic        tx_rd_o;
  logic [15:0] rx_data_o;
  logic        rx_wr_o;
  logic        rx_full_i;
  logic        clr_err_i;
  logic        busy_o;
  logic        tx_underrun_o;
  logic        rx_overrun_o;
  logic        frame_err_o;

  modport slave (
    input  sclk_i, cs_n_i, mosi_i, cpol_i, cpha_i, data_size_i,
           tx_data_i, tx_empty_i, rx_full_i, clr_err_i,
    output miso_o, miso_oe_o, tx_rd_o, rx_data_o, rx_wr_o, busy_o,
           tx_underrun_o, rx_overrun_o, frame_err_o
  );

  modport master (
    output sclk_i, cs_n_i, mosi_i, cpol_i, cpha_i, data_size_i,
           tx_data_i, tx_empty_i, rx_full_i, clr_err_i,
    input  miso_o, miso_oe_o, tx_rd_o, rx_data_o, rx_wr_o, busy_o,
           tx_underrun_o, rx_overrun_o, frame_err_o
  );
endinterface

// File: rtl/spi_target_controller.sv
// SPI target: oversampled sclk/cs_n/mosi, 1..16-bit frames, all four modes,
// word-level TX/RX FIFO handshake and sticky error flags.
//
// state | meaning
// IDLE  | waiting for a chip-select falling edge
// LOAD  | one cycle: pop TX word (or zeros on underrun), latch frame config
// SHIFT | sampling mosi / shifting miso on synced sclk edges
// DONE  | one cycle: push received word (or flag overrun)
module spi_target_controller #(
  parameter int SYNC_STAGES = 2
) (
  input logic                    clk,
  input logic                    rst_n,
  spi_target_controller_if.slave bus
);

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_SHIFT, S_DONE} state_t;

  state_t r_state, w_state_nxt;

  logic [SYNC_STAGES-1:0] r_sclk_sync, r_cs_sync, r_mosi_sync;
  logic                   r_sclk_prev, r_cs_prev;

  logic [15:0] r_shift;
  logic [14:0] r_rx;
  logic [15:0] r_rx_data;
  logic [4:0]  r_bit_cnt;
  logic [3:0]  r_size;
  logic        r_cpol, r_cpha;
  logic        r_tx_underrun, r_rx_overrun, r_frame_err;

  logic w_sclk, w_cs_n, w_mosi;
  logic w_sclk_chg, w_lead, w_trail, w_cs_fall, w_cs_rise;
  logic w_first, w_sample, w_shift, w_last;
  logic w_load, w_tx_rd, w_rx_wr, w_set_unr, w_set_ovr, w_set_ferr;

  // sclk synchronizer resets to the configured idle level so that reset
  // release does not look like a clock edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sclk_sync <= {SYNC_STAGES{bus.cpol_i}};
      r_sclk_prev <= bus.cpol_i;
      r_cs_sync   <= '1;
      r_cs_prev   <= 1'b1;
      r_mosi_sync <= '0;
    end else begin
      r_sclk_sync <= {r_sclk_sync[SYNC_STAGES-2:0], bus.sclk_i};
      r_cs_sync   <= {r_cs_sync[SYNC_STAGES-2:0], bus.cs_n_i};
      r_mosi_sync <= {r_mosi_sync[SYNC_STAGES-2:0], bus.mosi_i};
      r_sclk_prev <= w_sclk;
      r_cs_prev   <= w_cs_n;
    end
  end

  assign w_sclk     = r_sclk_sync[SYNC_STAGES-1];
  assign w_cs_n     = r_cs_sync[SYNC_STAGES-1];
  assign w_mosi     = r_mosi_sync[SYNC_STAGES-1];
  assign w_sclk_chg = w_sclk ^ r_sclk_prev;
  assign w_lead     = w_sclk_chg & (w_sclk != r_cpol);
  assign w_trail    = w_sclk_chg & (w_sclk == r_cpol);
  assign w_cs_fall  = r_cs_prev & ~w_cs_n;
  assign w_cs_rise  = ~r_cs_prev & w_cs_n;

  // No shift before the first sample: this skips the launch edge in
  // cpha=1 and the previous frame's last trailing edge in back-to-back cpha=0.
  assign w_first  = (r_bit_cnt == 5'd0);
  assign w_sample = ~w_cs_n & (r_cpha ? w_trail : w_lead);
  assign w_shift  = ~w_cs_n & ~w_first & (r_cpha ? w_lead : w_trail);
  assign w_last   = (r_bit_cnt == {1'b0, r_size});

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_load      = 1'b0;
    w_tx_rd     = 1'b0;
    w_rx_wr     = 1'b0;
    w_set_unr   = 1'b0;
    w_set_ovr   = 1'b0;
    w_set_ferr  = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_cs_fall) w_state_nxt = S_LOAD;
      end
      S_LOAD: begin
        if (w_cs_rise) begin
          w_set_ferr  = 1'b1;
          w_state_nxt = S_IDLE;
        end else begin
          w_load      = 1'b1;
          w_tx_rd     = ~bus.tx_empty_i;
          w_set_unr   = bus.tx_empty_i;
          w_state_nxt = S_SHIFT;
        end
      end
      S_SHIFT: begin
        if (w_cs_rise) begin
          w_set_ferr  = 1'b1;
          w_state_nxt = S_IDLE;
        end else if (w_sample && w_last) begin
          w_state_nxt = S_DONE;
        end
      end
      S_DONE: begin
        w_rx_wr     = ~bus.rx_full_i;
        w_set_ovr   = bus.rx_full_i;
        w_state_nxt = w_cs_n ? S_IDLE : S_LOAD;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_shift   <= '0;
      r_rx      <= '0;
      r_rx_data <= '0;
      r_bit_cnt <= '0;
      r_size    <= '0;
      r_cpol    <= 1'b0;
      r_cpha    <= 1'b0;
    end else if (w_load) begin
      r_shift   <= bus.tx_empty_i ? 16'h0000 : bus.tx_data_i;
      r_rx      <= '0;
      r_bit_cnt <= '0;
      r_size    <= bus.data_size_i;
      r_cpol    <= bus.cpol_i;
      r_cpha    <= bus.cpha_i;
    end else if (r_state == S_SHIFT && !w_cs_rise) begin
      if (w_sample) begin
        r_rx      <= {r_rx[13:0], w_mosi};
        r_bit_cnt <= r_bit_cnt + 5'd1;
        if (w_last) r_rx_data <= {r_rx, w_mosi};
      end
      if (w_shift) r_shift <= {r_shift[14:0], 1'b0};
    end
  end

  // Sticky flags: a set in the same cycle as a clear takes priority.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_tx_underrun <= 1'b0;
      r_rx_overrun  <= 1'b0;
      r_frame_err   <= 1'b0;
    end else begin
      r_tx_underrun <= w_set_unr  | (r_tx_underrun & ~bus.clr_err_i);
      r_rx_overrun  <= w_set_ovr  | (r_rx_overrun  & ~bus.clr_err_i);
      r_frame_err   <= w_set_ferr | (r_frame_err   & ~bus.clr_err_i);
    end
  end

  assign bus.miso_o        = r_shift[r_size];
  assign bus.miso_oe_o     = ~w_cs_n & (r_state != S_IDLE);
  assign bus.busy_o        = (r_state != S_IDLE);
  assign bus.tx_rd_o       = w_tx_rd;
  assign bus.rx_wr_o       = w_rx_wr;
  assign bus.rx_data_o     = r_rx_data;
  assign bus.tx_underrun_o = r_tx_underrun;
  assign bus.rx_overrun_o  = r_rx_overrun;
  assign bus.frame_err_o   = r_frame_err;

endmodule

// File: tb/tb_spi_target_controller.sv
// Directed and randomized frames against a word-level model of the target:
// MISO must reproduce the popped TX word, pushed RX word must equal MOSI.
module tb_spi_target_controller;
  localparam int H = 8;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  spi_target_controller_if bus();

  spi_target_controller #(.SYNC_STAGES(2)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  int          n_chk = 0;
  int          n_err = 0;
  int          n_rd  = 0;
  logic [15:0] tx_q[$];
  logic [15:0] rx_q[$];
  bit          pop_pend = 1'b0;

  // TX FIFO model (pop lands one cycle after tx_rd_o) and RX/pop monitor.
  always @(negedge clk) begin
    if (!rst_n) begin
      pop_pend = 1'b0;
    end else begin
      if (pop_pend && tx_q.size() > 0) void'(tx_q.pop_front());
      pop_pend = bus.tx_rd_o;
      if (bus.tx_rd_o) n_rd++;
      if (bus.rx_wr_o) rx_q.push_back(bus.rx_data_o);
    end
    bus.tx_empty_i = (tx_q.size() == 0);
    bus.tx_data_i  = (tx_q.size() == 0) ? 16'h0000 : tx_q[0];
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic clks(input int n);
    repeat (n) @(negedge clk);
  endtask

  function automatic logic [15:0] msk(input int sz);
    logic [16:0] m;
    m = (17'd1 << (sz + 1)) - 17'd1;
    return m[15:0];
  endfunction

  function automatic logic [2:0] flags();
    return {bus.tx_underrun_o, bus.rx_overrun_o, bus.frame_err_o};
  endfunction

  task automatic set_cfg(input bit cpol, input bit cpha, input int sz);
    bus.cpol_i      = cpol;
    bus.cpha_i      = cpha;
    bus.data_size_i = sz[3:0];
    bus.sclk_i      = cpol;
    clks(2 * H);
  endtask

  // Host side of nb bits; rel=1 raises cs_n right after the final sampling edge.
  task automatic do_frame(input int nb, input logic [15:0] mo, input bit rel,
                          output logic [15:0] mi);
    mi = '0;
    for (int i = nb - 1; i >= 0; i--) begin
      if (!bus.cpha_i) begin
        bus.mosi_i = mo[i];
        clks(H);
        mi = {mi[14:0], bus.miso_o};
        bus.sclk_i = ~bus.cpol_i;
        if (rel && i == 0) begin
          clks(1);
          bus.cs_n_i = 1'b1;
        end
        clks(H);
        bus.sclk_i = bus.cpol_i;
      end else begin
        bus.sclk_i = ~bus.cpol_i;
        bus.mosi_i = mo[i];
        clks(H);
        mi = {mi[14:0], bus.miso_o};
        bus.sclk_i = bus.cpol_i;
        if (rel && i == 0) begin
          clks(1);
          bus.cs_n_i = 1'b1;
        end
        clks(H);
      end
    end
  endtask

  task automatic single(input logic [15:0] mo, output logic [15:0] mi);
    bus.cs_n_i = 1'b0;
    clks(H);
    do_frame(int'(bus.data_size_i) + 1, mo, 1'b1, mi);
    clks(4 * H);
  endtask

  task automatic clr_pulse();
    bus.clr_err_i = 1'b1;
    clks(1);
    bus.clr_err_i = 1'b0;
    clks(1);
  endtask

  initial begin
    logic [15:0] mi, mi2, mo, mo2, tx;
    int          rd0, q0, sz;
    bit          pol, pha;

    rst_n           = 1'b0;
    bus.sclk_i      = 1'b0;
    bus.cs_n_i      = 1'b1;
    bus.mosi_i      = 1'b0;
    bus.cpol_i      = 1'b0;
    bus.cpha_i      = 1'b0;
    bus.data_size_i = 4'd7;
    bus.rx_full_i   = 1'b0;
    bus.clr_err_i   = 1'b0;
    clks(3);
    chk("reset_outs", {bus.miso_o, bus.miso_oe_o, bus.tx_rd_o, bus.rx_wr_o, bus.busy_o, flags()}, 0);
    chk("reset_rx_data", bus.rx_data_o, 0);
    rst_n = 1'b1;
    clks(4);

    // Mode 0, 8 bits
    rd0 = n_rd; q0 = rx_q.size();
    tx_q.push_back(16'h00A5);
    set_cfg(0, 0, 7);
    single(16'h003C, mi);
    chk("m0_miso", mi, 16'h00A5);
    chk("m0_pops", n_rd - rd0, 1);
    chk("m0_pushes", rx_q.size() - q0, 1);
    chk("m0_rx", rx_q[$], 16'h003C);
    chk("m0_flags", flags(), 0);
    chk("m0_idle", bus.busy_o, 0);

    // Mode 3, 16 bits
    rd0 = n_rd; q0 = rx_q.size();
    tx_q.push_back(16'h1234);
    set_cfg(1, 1, 15);
    single(16'hBEEF, mi);
    chk("m3_miso", mi, 16'h1234);
    chk("m3_pushes", rx_q.size() - q0, 1);
    chk("m3_rx", rx_q[$], 16'hBEEF);
    chk("m3_pops", n_rd - rd0, 1);

    // Two frames under one chip select
    rd0 = n_rd; q0 = rx_q.size();
    mo  = 16'($urandom_range(0, 255));
    mo2 = 16'($urandom_range(0, 255));
    tx_q.push_back(16'h0011);
    tx_q.push_back(16'h0022);
    set_cfg(0, 0, 7);
    bus.cs_n_i = 1'b0;
    clks(H);
    do_frame(8, mo, 1'b0, mi);
    do_frame(8, mo2, 1'b1, mi2);
    clks(4 * H);
    chk("b2b_miso1", mi, 16'h0011);
    chk("b2b_miso2", mi2, 16'h0022);
    chk("b2b_pops", n_rd - rd0, 2);
    chk("b2b_pushes", rx_q.size() - q0, 2);
    chk("b2b_rx1", rx_q[$-1], mo);
    chk("b2b_rx2", rx_q[$], mo2);
    chk("b2b_flags", flags(), 0);

    // TX underrun
    rd0 = n_rd; q0 = rx_q.size();
    mo = 16'($urandom_range(0, 255));
    single(mo, mi);
    chk("unr_miso", mi, 16'h0000);
    chk("unr_pops", n_rd - rd0, 0);
    chk("unr_rx", rx_q[$], mo);
    chk("unr_flags", flags(), 3'b100);
    clr_pulse();
    chk("unr_clr", flags(), 0);

    // Abort after 3 of 8 bits, then a clean frame
    rd0 = n_rd; q0 = rx_q.size();
    tx_q.push_back(16'h005A);
    tx_q.push_back(16'h0077);
    bus.cs_n_i = 1'b0;
    clks(H);
    do_frame(3, 16'h0005, 1'b0, mi);
    clks(H);
    bus.cs_n_i = 1'b1;
    clks(4 * H);
    chk("abort_flags", flags(), 3'b001);
    chk("abort_idle", bus.busy_o, 0);
    chk("abort_pushes", rx_q.size() - q0, 0);
    chk("abort_pops", n_rd - rd0, 1);
    mo = 16'($urandom_range(0, 255));
    single(mo, mi);
    chk("after_abort_miso", mi, 16'h0077);
    chk("after_abort_rx", rx_q[$], mo);
    chk("after_abort_pushes", rx_q.size() - q0, 1);
    clr_pulse();

    // RX overrun
    q0 = rx_q.size();
    bus.rx_full_i = 1'b1;
    tx_q.push_back(16'h00C3);
    single(16'h0081, mi);
    bus.rx_full_i = 1'b0;
    chk("ovr_pushes", rx_q.size() - q0, 0);
    chk("ovr_flags", flags(), 3'b010);
    chk("ovr_miso", mi, 16'h00C3);

    // Reset mid-frame
    tx_q.push_back(16'h00F0);
    set_cfg(0, 1, 7);
    bus.cs_n_i = 1'b0;
    clks(H);
    do_frame(3, 16'h0007, 1'b0, mi);
    chk("midframe_busy", bus.busy_o, 1);
    rst_n = 1'b0;
    #1;
    chk("rst_mid_outs", {bus.miso_o, bus.miso_oe_o, bus.tx_rd_o, bus.rx_wr_o, bus.busy_o, flags()}, 0);
    chk("rst_mid_rx_data", bus.rx_data_o, 0);
    clks(1);
    bus.cs_n_i = 1'b1;
    tx_q.delete();
    clks(2);
    rst_n = 1'b1;
    clks(4 * H);
    chk("post_rst_flags", flags(), 0);

    // Randomized frames over all modes and sizes
    for (int k = 0; k < 8; k++) begin
      pol = 1'($urandom_range(0, 1));
      pha = 1'($urandom_range(0, 1));
      sz  = $urandom_range(0, 15);
      tx  = 16'($urandom());
      mo  = 16'($urandom());
      rd0 = n_rd; q0 = rx_q.size();
      tx_q.push_back(tx);
      set_cfg(pol, pha, sz);
      single(mo, mi);
      chk($sformatf("rnd%0d_miso", k), mi, tx & msk(sz));
      chk($sformatf("rnd%0d_rx", k), rx_q[$], mo & msk(sz));
      chk($sformatf("rnd%0d_xfers", k), {n_rd - rd0, 32'(rx_q.size() - q0)}, {32'd1, 32'd1});
    end
    chk("final_flags", flags(), 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: observed=running expected=finished");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/spi_target_controller.md
SPI_TARGET_CONTROLLER -- requirements
Module: spi_target_controller

Interface
REQ-001 SHALL have parameter SYNC_STAGES, default 2: synchronizer depth for sclk_i, cs_n_i and mosi_i; legal range 2..3.
REQ-002 SHALL have port clk, input, 1 bit: system clock; all logic on its rising edge.
REQ-003 SHALL have port rst_n, input, 1 bit: reset, asynchronous, active-low.
REQ-004 SHALL have port sclk_i, input, 1 bit: SPI clock from the initiator; asynchronous to clk.
REQ-005 SHALL have port cs_n_i, input, 1 bit: chip select, active-low; asynchronous to clk.
REQ-006 SHALL have port mosi_i, input, 1 bit: serial data in.
REQ-007 SHALL have port miso_o, output, 1 bit: serial data out.
REQ-008 SHALL have port miso_oe_o, output, 1 bit: output enable for the miso pad.
REQ-009 SHALL have port cpol_i, input, 1 bit: idle level of sclk.
REQ-010 SHALL have port cpha_i, input, 1 bit: 0 = sample on leading edge, 1 = sample on trailing edge.
REQ-011 SHALL have port data_size_i, input, 4 bits: frame length in bits minus 1 (1..16 bits).
REQ-012 SHALL have port tx_data_i, input, 16 bits: TX FIFO head word; only bits [data_size:0] are used.
REQ-013 SHALL have port tx_empty_i, input, 1 bit: TX FIFO empty.
REQ-014 SHALL have port tx_rd_o, output, 1 bit: one-cycle TX FIFO pop.
REQ-015 SHALL have port rx_data_o, output, 16 bits: received word, right-aligned, unused upper bits 0.
REQ-016 SHALL have port rx_wr_o, output, 1 bit: one-cycle RX FIFO push.
REQ-017 SHALL have port rx_full_i, input, 1 bit: RX FIFO full.
REQ-018 SHALL have port clr_err_i, input, 1 bit: clears all sticky error flags.
REQ-019 SHALL have port busy_o, output, 1 bit: high when state is not IDLE.
REQ-020 SHALL have port tx_underrun_o, rx_overrun_o, frame_err_o, outputs, 1 bit each: sticky error flags.

Function
REQ-021 SHALL pass sclk_i, cs_n_i and mosi_i through SYNC_STAGES flops, then one edge-detect flop; an edge is visible SYNC_STAGES+1 clk cycles after the pin; clk SHALL be at least 8x sclk.
REQ-022 SHALL define the leading edge as a synced sclk transition away from cpol_i and the trailing edge as a transition back to cpol_i.
REQ-023 SHALL implement states IDLE, LOAD, SHIFT and DONE.
REQ-024 IDLE -> LOAD on a synced cs_n falling edge, or on synced cs_n low while in DONE.
REQ-025 In LOAD, for exactly one cycle:
- if tx_empty_i=0: assert tx_rd_o and load the shift register with tx_data_i.
- if tx_empty_i=1: load all zeros, set tx_underrun_o, do not assert tx_rd_o.
- then go to SHIFT with bit_cnt=0.
REQ-026 miso_o SHALL equal shift register bit [data_size_i]; transmission SHALL be MSB first.
REQ-027 When cpha_i=0: sample mosi on the leading edge; shift the TX register left on the trailing edge.
REQ-028 When cpha_i=1: shift the TX register left on the leading edge, except the first leading edge of the frame; sample on the trailing edge.
REQ-029 Each sample SHALL shift the synced mosi into the RX register LSB and increment bit_cnt (5 bits).
REQ-030 The sample with bit_cnt==data_size_i SHALL move SHIFT -> DONE.
REQ-031 In DONE, for one cycle:
- if rx_full_i=0: pulse rx_wr_o with rx_data_o valid in the same cycle.
- if rx_full_i=1: do not pulse rx_wr_o; set rx_overrun_o.
- then go to LOAD if synced cs_n is low, else IDLE.
REQ-032 A synced cs_n rising edge in LOAD or SHIFT SHALL abort to IDLE, set frame_err_o and produce no rx_wr_o; any partial word SHALL be discarded.
REQ-033 Sclk edges while synced cs_n is high SHALL be ignored.
REQ-034 miso_oe_o SHALL equal NOT synced cs_n, gated with state != IDLE.
REQ-035 data_size_i, cpol_i and cpha_i SHALL be sampled into internal registers in LOAD and held constant for the frame.
REQ-036 If clr_err_i and an error set occur in the same cycle, set SHALL win.
REQ-037 rx_data_o SHALL hold its value until the next DONE.

Reset
REQ-038 On rst_n low, all flops SHALL clear asynchronously: state=IDLE, synchronizers to their idle values (sclk = cpol_i, cs_n = 1), and all outputs 0.
REQ-039 Reset asserted mid-frame SHALL abort the frame with no rx_wr_o, no tx_rd_o and no error flag set.

Verification
REQ-040 Mode 0, data_size=7, tx_data=0xA5, MOSI 0x3C -> MISO bits 1,0,1,0,0,1,0,1; one tx_rd_o; one rx_wr_o with rx_data_o=0x003C.
REQ-041 Mode 3, data_size=15, tx_data=0x1234, MOSI 0xBEEF -> MISO 0x1234; rx_data_o=0xBEEF.
REQ-042 cs_n held low for two 8-bit frames, TX FIFO {0x11,0x22} -> two tx_rd_o, two rx_wr_o, MISO 0x11 then 0x22, no errors.
REQ-043 tx_empty_i=1 at LOAD -> MISO all 0, tx_underrun_o=1; clr_err_i pulse -> tx_underrun_o=0.
REQ-044 cs_n deasserted after 3 of 8 bits -> frame_err_o=1, no rx_wr_o, state=IDLE; the next full frame completes normally.
REQ-045 rx_full_i=1 at DONE -> no rx_wr_o, rx_overrun_o=1; rst_n asserted mid-frame -> all outputs 0 immediately.
